// File: rtl/vga_timing_gen.sv
// Free-running 800x600@60 raster timing source; itf_vga "out" signals flattened onto o_* ports.
// Optional colour-bar test pattern on o_rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [10:0] o_hcount,
    output logic [10:0] o_vcount,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_hblnk,
    output logic        o_vblnk,
    output logic [11:0] o_rgb,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_size
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit in 11-bit counts");
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic [11:0] r_rgb;
    logic        r_frame_start;

    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic        w_hblnk_nxt;
    logic        w_vblnk_nxt;
    logic [11:0] w_rgb_nxt;
    logic        w_frame_start_nxt;

    // Flags are computed from the next counts so they land in the same cycle as the counts.
    always_comb begin
        w_hcount_nxt = r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_nxt = '0;
            w_vcount_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 11'd1;
        end
        w_hblnk_nxt       = (w_hcount_nxt >= H_ACT);
        w_hsync_nxt       = (w_hcount_nxt >= HS_START) && (w_hcount_nxt < HS_END);
        w_vblnk_nxt       = (w_vcount_nxt >= V_ACT);
        w_vsync_nxt       = (w_vcount_nxt >= VS_START) && (w_vcount_nxt < VS_END);
        w_frame_start_nxt = (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [2:0] w_bar;

    always_comb begin
        w_bar     = 3'(w_hcount_nxt / BAR_W);
        w_rgb_nxt = 12'h000;
        if (!w_hblnk_nxt && !w_vblnk_nxt) begin
            case (w_bar)
                3'd0:    w_rgb_nxt = 12'hFFF;
                3'd1:    w_rgb_nxt = 12'hFF0;
                3'd2:    w_rgb_nxt = 12'h0FF;
                3'd3:    w_rgb_nxt = 12'h0F0;
                3'd4:    w_rgb_nxt = 12'hF0F;
                3'd5:    w_rgb_nxt = 12'hF00;
                3'd6:    w_rgb_nxt = 12'h00F;
                default: w_rgb_nxt = 12'h000;
            endcase
        end
    end
`else
    always_comb begin
        w_rgb_nxt = 12'h000;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_rgb         <= 12'h000;
            r_frame_start <= 1'b1;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_hblnk       <= w_hblnk_nxt;
            r_vblnk       <= w_vblnk_nxt;
            r_rgb         <= w_rgb_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_hblnk       = r_hblnk;
    assign o_vblnk       = r_vblnk;
    assign o_rgb         = r_rgb;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/line timing, scaled-down instance (25x15) for frame wrap,
// vertical flags and mid-frame reset, which are out of reach at full size within a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount;
    logic        a_hsync, a_vsync, a_hblnk, a_vblnk, a_fs;
    logic        b_hsync, b_vsync, b_hblnk, b_vblnk, b_fs;
    logic [11:0] a_rgb, b_rgb;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen u_dut_a (
        .i_clk(clk), .i_rst(rst_a),
        .o_hcount(a_hcount), .o_vcount(a_vcount),
        .o_hsync(a_hsync), .o_vsync(a_vsync),
        .o_hblnk(a_hblnk), .o_vblnk(a_vblnk),
        .o_rgb(a_rgb), .o_frame_start(a_fs)
    );

    // Small raster: H 16/2/4/3 (total 25), V 10/1/2/2 (total 15), frame = 375 cycles.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_ACTIVE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst_b),
        .o_hcount(b_hcount), .o_vcount(b_vcount),
        .o_hsync(b_hsync), .o_vsync(b_vsync),
        .o_hblnk(b_hblnk), .o_vblnk(b_vblnk),
        .o_rgb(b_rgb), .o_frame_start(b_fs)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] exp_rgb(input int h, input int v, input int h_act, input int v_act);
        logic [11:0] pal [8];
        pal = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef VGA_TEST_PATTERN_EN
        if (h < h_act && v < v_act) return pal[h / (h_act / 8)];
`endif
        return 12'h000;
    endfunction

    task automatic test_reset;
        logic [41:0] act;
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            act = {a_hcount, a_vcount, a_hsync, a_vsync, a_hblnk, a_vblnk, a_rgb, a_fs};
            n_cmp++;
            if (act !== {11'd0, 11'd0, 4'b0000, 12'h000, 1'b1}) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, act, {11'd0, 11'd0, 4'b0000, 12'h000, 1'b1});
            end
        end
        rst_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_hcount, a_vcount, a_fs} !== {11'd1, 11'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: got h=%0d v=%0d fs=%0b expected h=1 v=0 fs=0", a_hcount, a_vcount, a_fs);
        end
    endtask

    task automatic test_line_wrap;
        int hs_cnt, hs_first, hs_last;
        cyc(798);
        n_cmp++;
        if ({a_hcount, a_hblnk} !== {11'd799, 1'b0}) begin
            n_err++;
            $display("FAIL hblnk_799: got h=%0d hblnk=%0b expected h=799 hblnk=0", a_hcount, a_hblnk);
        end
        cyc(1);
        n_cmp++;
        if ({a_hcount, a_hblnk} !== {11'd800, 1'b1}) begin
            n_err++;
            $display("FAIL hblnk_800: got h=%0d hblnk=%0b expected h=800 hblnk=1", a_hcount, a_hblnk);
        end
        hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int p = 800; p <= 1055; p++) begin
            if (a_hsync === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = p;
                hs_last = p;
            end
            if (p < 1055) cyc(1);
        end
        n_cmp++;
        if (hs_cnt != 128 || hs_first != 840 || hs_last != 967) begin
            n_err++;
            $display("FAIL hsync_window: got cnt=%0d first=%0d last=%0d expected 128/840/967", hs_cnt, hs_first, hs_last);
        end
        n_cmp++;
        if ({a_hcount, a_vcount} !== {11'd1055, 11'd0}) begin
            n_err++;
            $display("FAIL line_end: got h=%0d v=%0d expected h=1055 v=0", a_hcount, a_vcount);
        end
        cyc(1);
        n_cmp++;
        if ({a_hcount, a_vcount, a_hsync, a_vsync, a_hblnk, a_vblnk, a_fs} !== {11'd0, 11'd1, 5'b00000}) begin
            n_err++;
            $display("FAIL line_wrap: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b fs=%0b expected h=0 v=1 flags 0",
                     a_hcount, a_vcount, a_hsync, a_vsync, a_hblnk, a_vblnk, a_fs);
        end
    endtask

    // Called at (0,1) of the full-size instance; walks one line checking rgb per pixel.
    task automatic test_rgb;
        logic [11:0] exp;
        for (int p = 0; p <= 1055; p++) begin
            exp = exp_rgb(p, 1, 800, 600);
            n_cmp++;
            if (a_rgb !== exp || a_hcount !== 11'(p)) begin
                n_err++;
                $display("FAIL rgb_line h=%0d: got rgb=%h h=%0d expected rgb=%h", p, a_rgb, a_hcount, exp);
            end
            cyc(1);
        end
    endtask

    task automatic test_frame_wrap;
        logic [41:0] act, exp;
        int h, v, fs_cnt, fs_prev, fs_period;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        fs_cnt = 0; fs_prev = 0; fs_period = 0;
        for (int i = 1; i <= 750; i++) begin
            @(negedge clk);
            h = i % 25;
            v = (i / 25) % 15;
            exp = {11'(h), 11'(v), (h >= 18 && h < 22), (v >= 11 && v < 13), (h >= 16), (v >= 10),
                   exp_rgb(h, v, 16, 10), (h == 0 && v == 0)};
            act = {b_hcount, b_vcount, b_hsync, b_vsync, b_hblnk, b_vblnk, b_rgb, b_fs};
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL frame_walk i=%0d: got %h expected %h", i, act, exp);
            end
            if (b_fs === 1'b1) begin
                fs_cnt++;
                fs_period = i - fs_prev;
                fs_prev = i;
            end
        end
        n_cmp++;
        if (fs_cnt != 2 || fs_period != 375) begin
            n_err++;
            $display("FAIL frame_period: got pulses=%0d period=%0d expected 2/375", fs_cnt, fs_period);
        end
    endtask

    // Entered at (0,0) of the small instance.
    task automatic test_reset_mid;
        logic [41:0] act;
        cyc(133);
        n_cmp++;
        if ({b_hcount, b_vcount} !== {11'd8, 11'd5}) begin
            n_err++;
            $display("FAIL mid_position: got h=%0d v=%0d expected h=8 v=5", b_hcount, b_vcount);
        end
        rst_b = 1'b1;
        @(negedge clk);
        act = {b_hcount, b_vcount, b_hsync, b_vsync, b_hblnk, b_vblnk, b_rgb, b_fs};
        n_cmp++;
        if (act !== {11'd0, 11'd0, 4'b0000, 12'h000, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset: got %h expected %h", act, {11'd0, 11'd0, 4'b0000, 12'h000, 1'b1});
        end
        rst_b = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b_hcount, b_vcount, b_fs} !== {11'd1, 11'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_resume: got h=%0d v=%0d fs=%0b expected h=1 v=0 fs=0", b_hcount, b_vcount, b_fs);
        end
        cyc(24);
        n_cmp++;
        if ({b_hcount, b_vcount, b_hsync, b_hblnk} !== {11'd0, 11'd1, 2'b00}) begin
            n_err++;
            $display("FAIL mid_next_line: got h=%0d v=%0d hs=%0b hb=%0b expected h=0 v=1 hs=0 hb=0",
                     b_hcount, b_vcount, b_hsync, b_hblnk);
        end
    endtask

    initial begin
        test_reset;
        test_line_wrap;
        test_rgb;
        test_frame_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
